// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART 8N1 to register-bus command bridge; optional CMD_TIMEOUT_EN aborts a stalled write
module uart_cmd_bridge #(
    parameter int UART_CLK_FREQ = 24_000_000,
    parameter int UART_BAUD     = 115_200,
    parameter int TIMEOUT_BITS  = 32
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    input  logic [7:0] rdata,
    output logic [7:0] wdata,
    output logic [6:0] addr,
    output logic       write,
    output logic       read_ack,
    output logic       frame_err
);

    localparam int BAUD_DIV = UART_CLK_FREQ / UART_BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [1:0] {P_CMD, P_DATA, P_RD} p_state_t;

    logic             r_rxd_meta;
    logic             r_rxd_sync;
    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;

    tx_state_t        r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [3:0]       r_tx_left;
    logic [8:0]       r_tx_shift;
    logic             r_txd;

    p_state_t         r_p_state;
    logic [6:0]       r_addr;
    logic [7:0]       r_wdata;
    logic             r_write;
    logic             r_read_ack;
    logic             r_frame_err;

    logic             w_rx_done;
    logic             w_rx_valid;
    logic             w_rx_ferr;

`ifdef CMD_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_BITS * BAUD_DIV - 1);
    logic [31:0]      r_to_cnt;
`endif

    // Stop-bit sample point: good stop hands the byte to the parser, bad stop flags a framing error
    assign w_rx_done  = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);
    assign w_rx_valid = w_rx_done &  r_rxd_sync;
    assign w_rx_ferr  = w_rx_done & ~r_rxd_sync;

    assign uart_txd  = r_txd;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign write     = r_write;
    assign read_ack  = r_read_ack;
    assign frame_err = r_frame_err;

    // Two-flop synchroniser for the asynchronous serial input, idling high
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    // Receiver: find start edge, re-check it half a bit later, then sample mid-bit LSB first
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rxd_sync) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                    end else if (!r_rxd_sync) begin
                        r_rx_state <= RX_DATA;
                        r_rx_cnt   <= BIT_LAST;
                        r_rx_bit   <= '0;
                    end else begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                    end else begin
                        r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
                        r_rx_cnt   <= BIT_LAST;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                    end else begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Transmitter: load {stop, rdata} while driving the start bit, then shift one bit per baud period
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_left  <= '0;
            r_tx_shift <= '1;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (r_read_ack) begin
                        r_tx_state <= TX_SHIFT;
                        r_txd      <= 1'b0;
                        r_tx_shift <= {1'b1, rdata};
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_left  <= 4'd9;
                    end
                end
                TX_SHIFT: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                    end else if (r_tx_left == 4'd0) begin
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                        r_tx_left  <= r_tx_left - 4'd1;
                        r_tx_cnt   <= BIT_LAST;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Command parser: decode command byte, issue write or read strobes, flag dropped/aborted bytes
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_p_state   <= P_CMD;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_read_ack  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            r_write     <= 1'b0;
            r_read_ack  <= 1'b0;
            r_frame_err <= w_rx_ferr;
            case (r_p_state)
                P_CMD: begin
                    if (w_rx_valid) begin
                        r_addr    <= r_rx_shift[6:0];
                        r_p_state <= r_rx_shift[7] ? P_DATA : P_RD;
`ifdef CMD_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                    end
                end
                P_DATA: begin
                    if (w_rx_valid) begin
                        r_wdata   <= r_rx_shift;
                        r_write   <= 1'b1;
                        r_p_state <= P_CMD;
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_frame_err <= 1'b1;
                        r_p_state   <= P_CMD;
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
`endif
                end
                P_RD: begin
                    // A new byte cannot be queued behind a pending read, so it is discarded
                    if (w_rx_valid) begin
                        r_frame_err <= 1'b1;
                    end
                    if (r_tx_state == TX_IDLE) begin
                        r_read_ack <= 1'b1;
                        r_p_state  <= P_CMD;
                    end
                end
                default: r_p_state <= P_CMD;
            endcase
        end
    end

endmodule
